// File: rtl/mips_pkg.sv
// Shared register-file constants and writeback request types.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int PORT_ALU  = 0;
  localparam int PORT_LOAD = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer: captures a request, holds it until the arbiter clears it.
// Latency: request visible as full on the cycle after the accepting edge.
// Backpressure: ready is simply !full; writes to r0 are accepted and dropped.
module wb_slot #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              in_ready,
  output logic              load,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Ready depends only on stored state, so there is no valid-to-ready path.
  assign in_ready = !full;

  // A transfer to r0 completes the handshake but never occupies the buffer.
  assign load = in_valid && !full && (in_addr != '0);

  // Load and clear are mutually exclusive: load needs empty, clear needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load-unit writebacks onto the register file's single write port, oldest first.
// Latency: accept at edge N -> WE/W_Addr/W_Data valid after edge N+1 (N+2 if arbitration lost once).
// Backpressure: per-port ready = buffer empty; optional Busy scoreboard under macro WB_BUSY_EN.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TIE_PORT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req_Valid_0,
  output logic              Req_Ready_0,
  input  logic [ADDR_W-1:0] Req_Addr_0,
  input  logic [DATA_W-1:0] Req_Data_0,
  input  logic              Req_Valid_1,
  output logic              Req_Ready_1,
  input  logic [ADDR_W-1:0] Req_Addr_1,
  input  logic [DATA_W-1:0] Req_Data_1,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic [31:0]       Busy,
  output logic              Idle
);

  logic              load0, load1;
  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1;
  // Index of the buffer that loaded first; only meaningful when both are full.
  logic              older;

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (Req_Valid_0),
    .in_addr  (Req_Addr_0),
    .in_data  (Req_Data_0),
    .clr      (gnt0),
    .in_ready (Req_Ready_0),
    .load     (load0),
    .full     (full0),
    .addr     (addr0),
    .data     (data0)
  );

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (Req_Valid_1),
    .in_addr  (Req_Addr_1),
    .in_data  (Req_Data_1),
    .clr      (gnt1),
    .in_ready (Req_Ready_1),
    .load     (load1),
    .full     (full1),
    .addr     (addr1),
    .data     (data1)
  );

  // Grant the sole full buffer, or the older one when both hold a write.
  always_comb begin
    gnt0 = full0 && (!full1 || (older == 1'(PORT_ALU)));
    gnt1 = full1 && (!full0 || (older == 1'(PORT_LOAD)));
  end

  // Age tracking: a lone load makes the other buffer the older one; a joint load
  // defers to TIE_PORT. A loading buffer was empty, so any full peer predates it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      older <= 1'b0;
    end else if (load0 && load1) begin
      older <= 1'(TIE_PORT);
    end else if (load0) begin
      older <= 1'(PORT_LOAD);
    end else if (load1) begin
      older <= 1'(PORT_ALU);
    end
  end

  // Output stage: register the granted write; address/data hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WE     <= 1'b0;
      W_Addr <= '0;
      W_Data <= '0;
    end else begin
      WE <= gnt0 || gnt1;
      if (gnt0) begin
        W_Addr <= addr0;
        W_Data <= data0;
      end else if (gnt1) begin
        W_Addr <= addr1;
        W_Data <= data1;
      end
    end
  end

  assign Idle = !full0 && !full1 && !WE;

`ifdef WB_BUSY_EN
  logic [NUM_REGS-1:0] busy_vec;

  // Mark every register with a write still buffered or on the write port; r0 never busy.
  always_comb begin
    busy_vec = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      busy_vec[k] = (full0 && (addr0 == ADDR_W'(k))) ||
                    (full1 && (addr1 == ADDR_W'(k))) ||
                    (WE && (W_Addr == ADDR_W'(k)));
    end
  end

  assign Busy = busy_vec;
`else
  assign Busy = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner case, random run vs queue model.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: random requesters hold addr/data while valid and not ready.
module tb_regfile_wb_arbiter;

  localparam int TIE = 0;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        v0, v1;
  logic        r0, r1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        WE;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [31:0] Busy;
  logic        Idle;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];
  int          wr_cnt = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .TIE_PORT(TIE)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Req_Valid_0 (v0),
    .Req_Ready_0 (r0),
    .Req_Addr_0  (a0),
    .Req_Data_0  (d0),
    .Req_Valid_1 (v1),
    .Req_Ready_1 (r1),
    .Req_Addr_1  (a1),
    .Req_Data_1  (d1),
    .WE          (WE),
    .W_Addr      (W_Addr),
    .W_Data      (W_Data),
    .Busy        (Busy),
    .Idle        (Idle)
  );

  always #5 CLK = ~CLK;

  // Register file that the arbiter drives.
  always @(posedge CLK) begin
    if (RST_N && WE) begin
      rf[W_Addr] <= W_Data;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] busy_exp(input logic [31:0] when_enabled);
`ifdef WB_BUSY_EN
    return when_enabled;
`else
    return 32'h0 & when_enabled;
`endif
  endfunction

  typedef struct {
    logic        v0; logic [4:0] a0; logic [31:0] d0;
    logic        v1; logic [4:0] a1; logic [31:0] d1;
    logic        we; logic [4:0] wa; logic [31:0] wd;
    logic        r0; logic        r1; logic idle;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                              input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                              input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic er0, input logic er1, input logic eidle,
                              input logic [31:0] ebusy);
    vec_t t;
    t.v0 = iv0; t.a0 = ia0; t.d0 = id0;
    t.v1 = iv1; t.a1 = ia1; t.d1 = id1;
    t.we = ewe; t.wa = ewa; t.wd = ewd;
    t.r0 = er0; t.r1 = er1; t.idle = eidle; t.busy = ebusy;
    return t;
  endfunction

  // Reference model: pending writes in acceptance order, one output stage.
  typedef struct { int port; logic [4:0] addr; logic [31:0] data; } pend_t;
  pend_t       pend[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic bit port_pending(input int p);
    foreach (pend[i]) if (pend[i].port == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (pend[i]) b[pend[i].addr] = 1'b1;
    if (m_we) b[m_wa] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit    acc0, acc1;
    pend_t e;
    acc0 = v0 && !port_pending(0);
    acc1 = v1 && !port_pending(1);
    if (pend.size() > 0) begin
      e    = pend.pop_front();
      m_we = 1'b1;
      m_wa = e.addr;
      m_wd = e.data;
    end else begin
      m_we = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      int p = (k == 0) ? TIE : 1 - TIE;
      if (p == 0 && acc0 && a0 != 0) pend.push_back('{0, a0, d0});
      if (p == 1 && acc1 && a1 != 0) pend.push_back('{1, a1, d1});
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    pend.delete();
    m_we = 0; m_wa = 0; m_wd = 0;
  endtask

  initial begin
    int cnt_snap;

    do_reset();
    @(negedge CLK);
    chk("rst_we", WE, 0);
    chk("rst_waddr", W_Addr, 0);
    chk("rst_wdata", W_Data, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_idle", Idle, 1);
    chk("rst_rdy0", r0, 1);
    chk("rst_rdy1", r1, 1);

    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,   0, 0, 0,            0, 1, 0, 32'h20);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,              1, 5, 32'hDEADBEEF, 1, 1, 0, 32'h20);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,              0, 5, 32'hDEADBEEF, 1, 1, 1, 32'h0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 32'h12345678,   0, 5, 32'hDEADBEEF, 1, 1, 1, 32'h0);
    tbl[4]  = mk(1, 7, 32'h1, 1, 7, 32'h2,      0, 5, 32'hDEADBEEF, 0, 0, 0, 32'h80);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,              1, 7, 32'h1,        1, 0, 0, 32'h80);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,              1, 7, 32'h2,        1, 1, 0, 32'h80);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,              0, 7, 32'h2,        1, 1, 1, 32'h0);
    tbl[8]  = mk(0, 0, 0, 1, 3, 32'h33,         0, 7, 32'h2,        1, 0, 0, 32'h8);
    tbl[9]  = mk(1, 4, 32'h44, 0, 0, 0,         1, 3, 32'h33,       0, 1, 0, 32'h18);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,              1, 4, 32'h44,       1, 1, 0, 32'h10);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,              0, 4, 32'h44,       1, 1, 1, 32'h0);

    for (int i = 0; i < 12; i++) begin
      v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      @(negedge CLK);
      chk($sformatf("vec%0d_we", i),   WE,     tbl[i].we);
      chk($sformatf("vec%0d_wa", i),   W_Addr, tbl[i].wa);
      chk($sformatf("vec%0d_wd", i),   W_Data, tbl[i].wd);
      chk($sformatf("vec%0d_rdy0", i), r0,     tbl[i].r0);
      chk($sformatf("vec%0d_rdy1", i), r1,     tbl[i].r1);
      chk($sformatf("vec%0d_idle", i), Idle,   tbl[i].idle);
      chk($sformatf("vec%0d_busy", i), Busy,   busy_exp(tbl[i].busy));
    end
    v0 = 0; v1 = 0;
    chk("rf7_last_writer", rf[7], 32'h2);
    chk("rf3", rf[3], 32'h33);
    chk("rf4", rf[4], 32'h44);

    // Busy for a single pending write to r9: buffer cycle, then write-port cycle.
    v0 = 1; a0 = 9; d0 = 32'h99;
    @(negedge CLK);
    v0 = 0;
    chk("busy9_c1", Busy, busy_exp(32'h200));
    @(negedge CLK);
    chk("busy9_c2", Busy, busy_exp(32'h200));
    @(negedge CLK);
    chk("busy9_c3", Busy, 0);

    // Reset in the middle of traffic with both buffers full.
    v0 = 1; a0 = 1; d0 = 32'hAAAA;
    v1 = 1; a1 = 2; d1 = 32'hBBBB;
    @(negedge CLK);
    v0 = 0; v1 = 0;
    chk("mid_full0", r0, 0);
    chk("mid_full1", r1, 0);
    cnt_snap = wr_cnt;
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_we", WE, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_idle", Idle, 1);
    chk("mid_rst_waddr", W_Addr, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("post_rst_we%0d", i), WE, 0);
    end
    chk("post_rst_rdy0", r0, 1);
    chk("post_rst_rdy1", r1, 1);
    chk("post_rst_writes", wr_cnt, cnt_snap);

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!(v0 && port_pending(0))) begin
        v0 = ($urandom_range(0, 9) < 6);
        a0 = 5'($urandom_range(0, 7));
        d0 = $urandom;
      end
      if (!(v1 && port_pending(1))) begin
        v1 = ($urandom_range(0, 9) < 6);
        a1 = 5'($urandom_range(0, 7));
        d1 = $urandom;
      end
      model_edge();
      @(negedge CLK);
      chk("rnd_we",   WE,     m_we);
      chk("rnd_wa",   W_Addr, m_wa);
      chk("rnd_wd",   W_Data, m_wd);
      chk("rnd_rdy0", r0,     !port_pending(0));
      chk("rnd_rdy1", r1,     !port_pending(1));
      chk("rnd_idle", Idle,   (pend.size() == 0) && !m_we);
      chk("rnd_busy", Busy,   busy_exp(model_busy()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 2-read/1-write MIPS register file between two writeback requesters: port 0 = ALU, port 1 = load unit.
- Each requester has a valid/ready handshake into a 1-entry buffer. An age-ordered arbiter drains the buffers into registered W_Addr/W_Data/WE outputs that drive the register file directly.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, data width of writes.
- ADDR_W, 5, register address width (32 registers).
- TIE_PORT, 0, port that wins when both buffers were loaded on the same edge (0 or 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Req_Valid_0  in  1  ALU write request valid.
- Req_Ready_0  out  1  buffer 0 can accept.
- Req_Addr_0  in  ADDR_W  ALU destination register.
- Req_Data_0  in  DATA_W  ALU result.
- Req_Valid_1  in  1  load write request valid.
- Req_Ready_1  out  1  buffer 1 can accept.
- Req_Addr_1  in  ADDR_W  load destination register.
- Req_Data_1  in  DATA_W  load data.
- WE  out  1  register-file write enable (registered).
- W_Addr  out  ADDR_W  register-file write address (registered).
- W_Data  out  DATA_W  register-file write data (registered).
- Busy  out  32  per-register pending-write scoreboard (see Optional Feature).
- Idle  out  1  both buffers empty and WE low.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Buffers empty, age bit cleared.
  - WE=0, W_Addr=0, W_Data=0, Busy=0, Idle=1.
  - Req_Ready_0 = Req_Ready_1 = 1 once reset is released.
- Reset asserted mid-operation discards buffered and in-flight writes; no partial write is issued.
- Handshake:
  - Req_Ready_i = !full_i. It is a registered-state function only, with no combinational path from Req_Valid.
  - A transfer occurs on an edge where Req_Valid_i && Req_Ready_i.
  - Requesters must hold Addr/Data stable while Valid is high and Ready is low.
- Writes to r0: a transfer with Req_Addr_i==0 is accepted and discarded. The buffer stays empty and WE is never raised for it.
- Buffer state per port: EMPTY -> FULL on a transfer with nonzero address; FULL -> EMPTY on the edge that grants it.
- A buffer that is FULL is not ready, so it cannot be loaded on the same edge it drains; Ready returns the cycle after grant.
- Arbitration, evaluated combinationally on buffer state each cycle:
  - Neither full: no grant.
  - One full: grant it.
  - Both full: grant the older buffer (age bit records which loaded first).
  - Both loaded on the same edge: grant TIE_PORT.
- Grant timing: on the granting edge, WE<=1, W_Addr<=buffer addr, W_Data<=buffer data, and the buffer clears. With no grant, WE<=0; W_Addr/W_Data hold their previous values.
- Latency: transfer at edge N -> WE high after edge N+1 -> register file commits at edge N+2. Minimum accept-to-commit is 2 cycles; worst case 3, when losing arbitration once.
- Ordering: writes to the same register from both ports commit in acceptance order. A simultaneous same-address acceptance commits TIE_PORT first, then the other (last writer wins).
- Throughput: 1 write per cycle sustained. Each port sustains 1 request per 2 cycles.
- Idle = !full_0 && !full_1 && !WE.

Optional Feature:
- Macro: WB_BUSY_EN.
- Defined:
  - Busy[k]=1 when k is the address held in a full buffer or in W_Addr with WE=1; Busy[0] is always 0.
  - Busy is computed combinationally from registered state.
  - Decode performs an OR over the buffers and the output stage.
- Not defined: Busy is tied to 32'b0 and no decode logic is generated.

Decomposition:
- Shared package (mips_pkg):
  - Constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - Typedef wb_req_t {addr, data}.
  - Port index constants PORT_ALU=0, PORT_LOAD=1.
- One sub-module, wb_slot: 1-entry buffer with valid/ready, load/clear and stored addr/data. It is instantiated twice.
- Arbitration, age tracking and output registers stay in the top level.

Test Plan:
- Reset then idle: RST_N low mid-stream with both buffers full -> WE=0, Busy=0, Idle=1, both Ready=1 after release; no write to the register file.
- Single ALU write: Valid_0 with addr 5, data 0xDEADBEEF at edge N -> WE=1, W_Addr=5, W_Data=0xDEADBEEF after edge N+1; WE=0 after edge N+2; Ready_0=0 for exactly 1 cycle.
- r0 discard: Valid_1 with addr 0, data 0x12345678 -> accepted, WE stays 0, Ready_1 stays 1, Busy=0.
- Simultaneous same address, TIE_PORT=0: port0 (addr 7, 0x1) and port1 (addr 7, 0x2) on the same edge -> WE pulses on 2 consecutive cycles, writing 0x1 then 0x2; register 7 reads 0x2.
- Age ordering: port1 loads addr 3 at edge N, port0 loads addr 4 at edge N+1 -> writes in order addr 3, then addr 4, back-to-back.
- Busy (WB_BUSY_EN): load addr 9 on port 0 -> Busy=0x00000200 for 2 cycles, then 0; without the macro, Busy=0 throughout.
